// File: rtl/tpu_sa_param.sv
// Output-stationary systolic engine computing C = (A + offset) * B on int8 operands,
// with masked edge tiles and optional ReLU on the write-back path.
module tpu_sa_param #(
  parameter int ARR  = 4,
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int IDXW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [8:0]          in_offset,
  input  logic                relu_en,
  input  logic [7:0]          K,
  input  logic [7:0]          M,
  input  logic [7:0]          N,
  output logic                busy,
  output logic                done,
  output logic [IDXW-1:0]     A_index,
  input  logic [ARR*DW-1:0]   A_data_out,
  output logic [IDXW-1:0]     B_index,
  input  logic [ARR*DW-1:0]   B_data_out,
  output logic                C_wr_en,
  output logic [IDXW-1:0]     C_index,
  output logic [ARR*ACCW-1:0] C_data_in
);

  localparam int AEW = ((DW > 9) ? DW : 9) + 1;
  localparam int PW  = AEW + DW;
  localparam int RW  = $clog2(ARR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [7:0]        tr;
  logic [7:0]        tc;
  logic [7:0]        k_dim;
  logic [7:0]        m_dim;
  logic [7:0]        n_dim;
  logic [7:0]        mt;
  logic [7:0]        nt;
  logic signed [8:0] offset;
  logic              relu;
  logic              feed_d;

  logic [8:0]          m_sum;
  logic [8:0]          n_sum;
  logic [7:0]          mt_calc;
  logic [7:0]          nt_calc;
  logic                last_tr;
  logic                last_tc;
  logic [7:0]          next_tr;
  logic [7:0]          next_tc;
  logic [IDXW-1:0]     a_base_next;
  logic [IDXW-1:0]     b_base_next;
  logic [IDXW-1:0]     c_index_next;
  logic [RW-1:0]       drain_row;
  logic                row_ok;
  logic [ARR*ACCW-1:0] drain_word;
  logic                tile_clear;

  logic signed [DW-1:0]   a_edge [ARR];
  logic signed [DW-1:0]   b_edge [ARR];
  logic signed [DW-1:0]   a_sr   [ARR][ARR];
  logic signed [DW-1:0]   b_sr   [ARR][ARR];
  logic signed [DW-1:0]   a_cur  [ARR][ARR];
  logic signed [DW-1:0]   b_cur  [ARR][ARR];
  logic signed [DW-1:0]   a_pipe [ARR][ARR];
  logic signed [DW-1:0]   b_pipe [ARR][ARR];
  logic signed [AEW-1:0]  a_eff  [ARR][ARR];
  logic signed [PW-1:0]   prod   [ARR][ARR];
  logic signed [ACCW-1:0] acc    [ARR][ARR];

  // Tile counts for the incoming job and tile-walk successors.
  always_comb begin
    m_sum       = {1'b0, M} + 9'(ARR - 1);
    n_sum       = {1'b0, N} + 9'(ARR - 1);
    mt_calc     = 8'(m_sum / 9'(ARR));
    nt_calc     = 8'(n_sum / 9'(ARR));
    last_tr     = (tr == mt - 8'd1);
    last_tc     = (tc == nt - 8'd1);
    next_tr     = last_tr ? 8'd0 : tr + 8'd1;
    next_tc     = last_tr ? tc + 8'd1 : tc;
    a_base_next = IDXW'(next_tr) * IDXW'(k_dim);
    b_base_next = IDXW'(next_tc) * IDXW'(k_dim);
    tile_clear  = (state == S_FEED) && (cnt == 8'd0);
  end

  // Row presented on the C port next cycle: row 0 from the last flush cycle, then one per drain cycle.
  always_comb begin
    if ((state == S_DRAIN) && (cnt < 8'(ARR - 1))) begin
      drain_row = RW'(cnt + 8'd1);
    end else begin
      drain_row = '0;
    end
    row_ok       = (16'(tr) * 16'(ARR) + 16'(drain_row)) < 16'(m_dim);
    c_index_next = IDXW'(tc) * IDXW'(m_dim) + IDXW'(tr) * IDXW'(ARR) + IDXW'(drain_row);
    drain_word   = '0;
    for (int c = 0; c < ARR; c++) begin
      if ((16'(tc) * 16'(ARR) + 16'(c)) >= 16'(n_dim)) begin
        drain_word[(ARR-1-c)*ACCW +: ACCW] = '0;
      end else if (relu && acc[drain_row][c][ACCW-1]) begin
        drain_word[(ARR-1-c)*ACCW +: ACCW] = '0;
      end else begin
        drain_word[(ARR-1-c)*ACCW +: ACCW] = acc[drain_row][c];
      end
    end
  end

  // Buffer words are only meaningful the cycle after a feed read; zeros otherwise.
  always_comb begin
    for (int r = 0; r < ARR; r++) begin
      a_edge[r] = feed_d ? A_data_out[(ARR-1-r)*DW +: DW] : '0;
      b_edge[r] = feed_d ? B_data_out[(ARR-1-r)*DW +: DW] : '0;
    end
  end

  // PE operand inputs: skewed edge values on the first row/column, forwarded values inside.
  always_comb begin
    a_cur[0][0] = a_edge[0];
    b_cur[0][0] = b_edge[0];
    for (int r = 1; r < ARR; r++) begin
      a_cur[r][0] = a_sr[r][r-1];
    end
    for (int c = 1; c < ARR; c++) begin
      b_cur[0][c] = b_sr[c][c-1];
    end
    for (int r = 0; r < ARR; r++) begin
      for (int c = 1; c < ARR; c++) begin
        a_cur[r][c] = a_pipe[r][c-1];
      end
    end
    for (int r = 1; r < ARR; r++) begin
      for (int c = 0; c < ARR; c++) begin
        b_cur[r][c] = b_pipe[r-1][c];
      end
    end
  end

  // Per-PE offset-adjusted multiply.
  always_comb begin
    for (int r = 0; r < ARR; r++) begin
      for (int c = 0; c < ARR; c++) begin
        a_eff[r][c] = AEW'(a_cur[r][c]) + AEW'(offset);
        prod[r][c]  = PW'(a_eff[r][c]) * PW'(b_cur[r][c]);
      end
    end
  end

  // Systolic datapath: edge skew chains, operand forwarding and accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feed_d <= 1'b0;
      for (int r = 0; r < ARR; r++) begin
        for (int c = 0; c < ARR; c++) begin
          a_sr[r][c]   <= '0;
          b_sr[r][c]   <= '0;
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          acc[r][c]    <= '0;
        end
      end
    end else begin
      feed_d <= (state == S_FEED);
      for (int r = 0; r < ARR; r++) begin
        a_sr[r][0] <= a_edge[r];
        b_sr[r][0] <= b_edge[r];
        for (int s = 1; s < ARR; s++) begin
          a_sr[r][s] <= a_sr[r][s-1];
          b_sr[r][s] <= b_sr[r][s-1];
        end
      end
      for (int r = 0; r < ARR; r++) begin
        for (int c = 0; c < ARR; c++) begin
          a_pipe[r][c] <= a_cur[r][c];
          b_pipe[r][c] <= b_cur[r][c];
          if (tile_clear) begin
            acc[r][c] <= '0;
          end else begin
            acc[r][c] <= acc[r][c] + ACCW'(prod[r][c]);
          end
        end
      end
    end
  end

  // Job sequencer: config latch, tile/phase counters, buffer indices and C write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tr        <= '0;
      tc        <= '0;
      k_dim     <= '0;
      m_dim     <= '0;
      n_dim     <= '0;
      mt        <= '0;
      nt        <= '0;
      offset    <= '0;
      relu      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      A_index   <= '0;
      B_index   <= '0;
      C_wr_en   <= 1'b0;
      C_index   <= '0;
      C_data_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          C_wr_en <= 1'b0;
          if (in_valid) begin
            k_dim  <= K;
            m_dim  <= M;
            n_dim  <= N;
            mt     <= mt_calc;
            nt     <= nt_calc;
            offset <= signed'(in_offset);
            relu   <= relu_en;
            tr     <= '0;
            tc     <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            if ((K == 8'd0) || (M == 8'd0) || (N == 8'd0)) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state   <= S_FEED;
              A_index <= '0;
              B_index <= '0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_FEED: begin
          if (cnt == k_dim - 8'd1) begin
            state <= S_FLUSH;
            cnt   <= '0;
          end else begin
            cnt     <= cnt + 8'd1;
            A_index <= A_index + IDXW'(1);
            B_index <= B_index + IDXW'(1);
          end
        end
        S_FLUSH: begin
          if (cnt == 8'(2 * ARR - 2)) begin
            state     <= S_DRAIN;
            cnt       <= '0;
            C_wr_en   <= row_ok;
            C_index   <= c_index_next;
            C_data_in <= drain_word;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (cnt == 8'(ARR - 1)) begin
            C_wr_en <= 1'b0;
            cnt     <= '0;
            if (last_tr && last_tc) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state   <= S_FEED;
              tr      <= next_tr;
              tc      <= next_tc;
              A_index <= a_base_next;
              B_index <= b_base_next;
            end
          end else begin
            cnt       <= cnt + 8'd1;
            C_wr_en   <= row_ok;
            C_index   <= c_index_next;
            C_data_in <= drain_word;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_sa_param.sv
// Randomised bench for tpu_sa_param (ARR=4): buffer models plus a plain matrix-product
// reference that predicts every C write, busy length and done placement.
module tb_tpu_sa_param;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [8:0]   in_offset;
  logic         relu_en;
  logic [7:0]   k_in;
  logic [7:0]   m_in;
  logic [7:0]   n_in;
  logic         busy;
  logic         done;
  logic [11:0]  a_index;
  logic [31:0]  a_data;
  logic [11:0]  b_index;
  logic [31:0]  b_data;
  logic         c_wr_en;
  logic [11:0]  c_index;
  logic [127:0] c_data;

  logic [31:0] amem [4096];
  logic [31:0] bmem [4096];
  int          a_mat [16][16];
  int          b_mat [16][16];
  logic [11:0]  exp_idx [$];
  logic [127:0] exp_dat [$];
  int           exp_busy;
  int checks;
  int failures;

  tpu_sa_param #(.ARR(4), .DW(8), .ACCW(32), .IDXW(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_offset  (in_offset),
    .relu_en    (relu_en),
    .K          (k_in),
    .M          (m_in),
    .N          (n_in),
    .busy       (busy),
    .done       (done),
    .A_index    (a_index),
    .A_data_out (a_data),
    .B_index    (b_index),
    .B_data_out (b_data),
    .C_wr_en    (c_wr_en),
    .C_index    (c_index),
    .C_data_in  (c_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= amem[a_index];
    b_data <= bmem[b_index];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    int x;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        x = $urandom_range(255);
        a_mat[i][j] = x - 128;
        x = $urandom_range(255);
        b_mat[i][j] = x - 128;
      end
    end
  endtask

  task automatic load_job(input int m, input int n, input int k, input int off, input bit relu);
    int mt;
    int nt;
    int s;
    logic [31:0]  w;
    logic [7:0]   bt;
    logic [127:0] row;
    logic signed [31:0] v;
    mt = (m + 3) / 4;
    nt = (n + 3) / 4;
    for (int i = 0; i < 4096; i++) begin
      amem[i] = 32'd0;
      bmem[i] = 32'd0;
    end
    for (int t = 0; t < mt; t++) begin
      for (int kk = 0; kk < k; kk++) begin
        for (int r = 0; r < 4; r++) begin
          bt = 8'(a_mat[t*4+r][kk]);
          w[(3-r)*8 +: 8] = bt;
        end
        amem[t*k+kk] = w;
      end
    end
    for (int t = 0; t < nt; t++) begin
      for (int kk = 0; kk < k; kk++) begin
        for (int c = 0; c < 4; c++) begin
          bt = 8'(b_mat[kk][t*4+c]);
          w[(3-c)*8 +: 8] = bt;
        end
        bmem[t*k+kk] = w;
      end
    end
    exp_idx.delete();
    exp_dat.delete();
    if (m == 0 || n == 0 || k == 0) begin
      exp_busy = 1;
    end else begin
      exp_busy = mt * nt * (k + 11) + 1;
      for (int tc = 0; tc < nt; tc++) begin
        for (int tr = 0; tr < mt; tr++) begin
          for (int r = 0; r < 4; r++) begin
            if (tr*4 + r < m) begin
              for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                  s = s + (a_mat[tr*4+r][kk] + off) * b_mat[kk][tc*4+c];
                end
                v = (tc*4 + c < n) ? 32'(s) : 32'sd0;
                if (relu && v < 0) v = 32'sd0;
                row[(3-c)*32 +: 32] = v;
              end
              exp_idx.push_back(12'(tc*m + tr*4 + r));
              exp_dat.push_back(row);
            end
          end
        end
      end
    end
  endtask

  task automatic launch(input int m, input int n, input int k, input int off, input bit relu);
    @(negedge clk);
    m_in      = 8'(m);
    n_in      = 8'(n);
    k_in      = 8'(k);
    in_offset = 9'(off);
    relu_en   = relu;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic run_job(input int m, input int n, input int k, input int off, input bit relu,
                         input bit poke);
    int busy_cyc;
    int done_cnt;
    int done_at;
    int first_wr;
    int wr;
    load_job(m, n, k, off, relu);
    launch(m, n, k, off, relu);
    busy_cyc = 0;
    done_cnt = 0;
    done_at  = -1;
    first_wr = -1;
    wr       = 0;
    for (int cyc = 0; cyc < 4000 && busy; cyc++) begin
      busy_cyc++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (c_wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (wr < exp_idx.size()) begin
          check("c_index", c_index, exp_idx[wr]);
          check("c_data", c_data, exp_dat[wr]);
        end
        wr++;
      end
      if (poke && cyc == 3) begin
        in_valid = 1'b1;
        k_in     = 8'($urandom_range(1, 255));
        m_in     = 8'($urandom_range(1, 255));
        relu_en  = ~relu;
        in_offset = 9'($urandom_range(511));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("busy_timeout", busy, 1'b0);
    check("busy_cycles", busy_cyc, exp_busy);
    check("done_pulses", done_cnt, 1);
    check("done_last_cycle", done_at, exp_busy - 1);
    check("done_low_after", done, 1'b0);
    check("write_count", wr, exp_idx.size());
    if (exp_idx.size() > 0) check("first_write_latency", first_wr, k + 7);
  endtask

  initial begin
    int seen;
    int x;
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_offset = 9'd0;
    relu_en   = 1'b0;
    k_in      = 8'd0;
    m_in      = 8'd0;
    n_in      = 8'd0;
    checks    = 0;
    failures  = 0;
    for (int i = 0; i < 4096; i++) begin
      amem[i] = 32'd0;
      bmem[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_en", c_wr_en, 1'b0);
    check("rst_a_index", a_index, 12'd0);
    check("rst_c_data", c_data, 128'd0);
    rst = 1'b0;

    // identity A: C rows equal B rows
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a_mat[i][j] = (i == j) ? 1 : 0;
        b_mat[i][j] = i * 4 + j;
      end
    end
    run_job(4, 4, 4, 0, 1'b0, 1'b0);
    check("identity_row0_const", exp_dat[0], {32'd0, 32'd1, 32'd2, 32'd3});

    // A = -128 with offset +128 cancels to zero
    fill_random();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a_mat[i][j] = -128;
      end
    end
    run_job(4, 4, 4, 128, 1'b0, 1'b0);

    // partial edge tiles
    fill_random();
    run_job(5, 6, 3, -3, 1'b0, 1'b0);

    // ReLU clamp and unclamped negative
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a_mat[i][j] = 1;
        b_mat[i][j] = -1;
      end
    end
    run_job(4, 4, 8, 0, 1'b1, 1'b0);
    run_job(4, 4, 8, 0, 1'b0, 1'b0);
    check("relu_off_value", exp_dat[0][127:96], 32'hFFFFFFF8);

    // zero dimension and mid-job in_valid
    run_job(4, 4, 0, 0, 1'b0, 1'b0);
    fill_random();
    run_job(7, 5, 6, 17, 1'b0, 1'b1);

    // reset during drain, then a clean job
    fill_random();
    load_job(8, 8, 5, 7, 1'b0);
    launch(8, 8, 5, 7, 1'b0);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (c_wr_en) seen = 1;
    end
    check("reached_drain", seen, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_wr_en", c_wr_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    run_job(6, 7, 4, -20, 1'b1, 1'b0);

    for (int j = 0; j < 6; j++) begin
      fill_random();
      x = $urandom_range(511);
      run_job($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 12),
              x - 256, 1'($urandom_range(1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
